// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode map, sequencer state encoding and ALU
// control codes used by control_unit and the multi-cycle sequencer.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } seq_state_t;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: is_legal_opcode = 1'b1;
      default:                           is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unanswered cycles of an outstanding memory request and flags
// expiry on the MAX_WAIT-th unanswered cycle (a same-cycle answer wins).
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic done_i,
  output logic expire_o
);

  localparam int W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Idle or answered requests hold the count at zero, so every new wait starts clean.
  always_comb begin
    cnt_d = '0;
    if (active_i && !done_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = active_i && !done_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control with memory
// handshakes, write-enable gating, retire counting and sticky traps.
module multicycle_sequencer
  import rv32_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic [6:0]       opcode,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             jump,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_trap,
  output logic             bus_err_trap,
  output logic [2:0]       state_dbg
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             wait_active, wait_done, wait_expire;

  // One timer serves both waits; only one request can be outstanding at a time.
  assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_done   = (state_q == S_FETCH) ? imem_ready : dmem_ready;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .active_i (wait_active),
    .done_i   (wait_done),
    .expire_o (wait_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready)       state_d = S_DECODE;
        else if (wait_expire) state_d = S_TRAP;
      end
      S_DECODE: state_d = is_legal_opcode(opcode) ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (mem_read || mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          if (mem_write) state_d = run ? S_FETCH : S_IDLE;
          else           state_d = S_WB;
        end else if (wait_expire) begin
          state_d = S_TRAP;
        end
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // A store retires straight out of MEM; everything else retires in WB.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    dmem_req = (state_q == S_MEM);
    dmem_we  = (state_q == S_MEM) && mem_write;
    rf_we    = (state_q == S_WB) && reg_write;
    ir_we    = (state_q == S_FETCH) && imem_ready;
    pc_we    = (state_q == S_WB) ||
               ((state_q == S_MEM) && dmem_ready && mem_write);
    pc_sel   = (state_q == S_WB) && (jump || (branch && branch_taken));
    retire   = pc_we;
  end

  always_comb begin
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    illegal_d = illegal_q || ((state_q == S_DECODE) && !is_legal_opcode(opcode));
    bus_err_d = bus_err_q || wait_expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instret      = instret_q;
  assign illegal_trap = illegal_q;
  assign bus_err_trap = bus_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: randomized instruction stream
// against an instruction-level model, plus trap and reset scenarios.
module tb_multicycle_sequencer;
  import rv32_pkg::*;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic rst, run, imem_ready, dmem_ready;
  logic reg_write, mem_read, mem_write, branch, jump, branch_taken;
  logic [6:0] opcode;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire;
  logic illegal_trap, bus_err_trap;
  logic [CNT_W-1:0] instret;
  logic [2:0] state_dbg;

  multicycle_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .opcode(opcode), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump),
    .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .retire(retire), .instret(instret),
    .illegal_trap(illegal_trap), .bus_err_trap(bus_err_trap),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   lat;
    int   rf_cnt;
    logic psel;
    logic dwe;
    int   dreq;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   exp_st[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   retire_total = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control bits a correct control_unit produces: {reg_write, mem_read, mem_write, branch, jump}
  function automatic logic [4:0] ctrl_of(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_IMM, OP_REG: ctrl_of = 5'b10000;
      OP_JAL, OP_JALR:                  ctrl_of = 5'b10001;
      OP_BRANCH:                        ctrl_of = 5'b00010;
      OP_LOAD:                          ctrl_of = 5'b11000;
      OP_STORE:                         ctrl_of = 5'b00100;
      default:                          ctrl_of = 5'b00000;
    endcase
  endfunction

  task automatic do_instr(input logic [6:0] opc, input int iw, input int dw,
                          input logic taken, input logic drop);
    exp_t e;
    logic [4:0] c;
    logic ld, st;
    int n;
    c  = ctrl_of(opc);
    ld = (opc == OP_LOAD);
    st = (opc == OP_STORE);
    exp_cnt++;
    e.lat    = (ld ? 5 : 4) + iw + ((ld || st) ? dw : 0);
    e.rf_cnt = c[4] ? 1 : 0;
    e.psel   = c[0] | (c[1] & taken);
    e.dwe    = st;
    e.dreq   = (ld || st) ? dw + 1 : 0;
    e.cnt    = exp_cnt;
    sb.push_back(e);
    for (int i = 0; i <= iw; i++) exp_st.push_back(1);
    exp_st.push_back(2);
    exp_st.push_back(3);
    if (ld || st) for (int i = 0; i <= dw; i++) exp_st.push_back(4);
    if (!st) exp_st.push_back(5);

    n = 0;
    while (!imem_req && n < 50) begin step(); n++; end
    chk("fetch_req", int'(imem_req), 1);
    repeat (iw) begin imem_ready = 1'b0; step(); end
    imem_ready = 1'b1;
    opcode = opc;
    {reg_write, mem_read, mem_write, branch, jump} = c;
    branch_taken = taken;
    step();
    imem_ready = 1'b0;
    if (drop) run = 1'b0;
    if (ld || st) begin
      n = 0;
      while (!dmem_req && n < 10) begin step(); n++; end
      chk("dmem_req_seen", int'(dmem_req), 1);
      repeat (dw) step();
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
    end
    if (!st) begin
      n = 0;
      while (!retire && n < 10) begin step(); n++; end
      chk("wb_retire", int'(retire), 1);
      step();
    end
    run = 1'b1;
  endtask

  // Monitor: tracks each instruction from its first fetch cycle to its retire pulse.
  initial begin : monitor
    bit in_instr;
    bit st_bad;
    int cyc, rfc, dreqc;
    bit dwe_seen;
    exp_t e;
    in_instr = 0;
    cyc = 0; rfc = 0; dreqc = 0; dwe_seen = 0; st_bad = 0;
    forever begin
      @(negedge clk);
      if (retire && !rst) retire_total++;
      if (rst || !mon_en) begin
        in_instr = 0;
      end else begin
        if (!in_instr && imem_req) begin
          in_instr = 1; cyc = 0; rfc = 0; dreqc = 0; dwe_seen = 0; st_bad = 0;
        end
        if (in_instr) begin
          cyc++;
          if (rf_we) rfc++;
          if (dmem_we) dwe_seen = 1;
          if (dmem_req) dreqc++;
          if (exp_st.size() == 0) st_bad = 1;
          else if (exp_st.pop_front() != int'(state_dbg)) st_bad = 1;
          if (retire) begin
            in_instr = 0;
            if (sb.size() == 0) begin
              chk("unexpected_retire", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("latency", cyc, e.lat);
              chk("rf_we_cycles", rfc, e.rf_cnt);
              chk("pc_sel", int'(pc_sel), int'(e.psel));
              chk("pc_we", int'(pc_we), 1);
              chk("dmem_we", int'(dwe_seen), int'(e.dwe));
              chk("dmem_req_cycles", dreqc, e.dreq);
              chk("state_trace_ok", int'(!st_bad), 1);
              chk("instret_before", int'(instret), e.cnt - 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin : stim
    logic [6:0] ops [9];
    int n, bad, rt0;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    opcode = 7'd0; reg_write = 0; mem_read = 0; mem_write = 0;
    branch = 0; jump = 0; branch_taken = 0;
    repeat (2) step();
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_instret", int'(instret), 0);
    chk("rst_illegal", int'(illegal_trap), 0);
    chk("rst_buserr", int'(bus_err_trap), 0);
    chk("rst_strobes", int'({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire}), 0);
    rst = 1'b0;
    step();
    chk("idle_no_run", int'(state_dbg), 0);

    mon_en = 1;
    run = 1'b1;
    do_instr(OP_IMM, 0, 0, 1'b0, 1'b0);
    chk("instret_after_addi", int'(instret), 1);
    do_instr(OP_LOAD, 0, 3, 1'b0, 1'b0);
    do_instr(OP_STORE, 0, 0, 1'b0, 1'b0);
    do_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0);
    chk("instret_after_4", int'(instret), 4);
    do_instr(OP_LOAD, 15, 15, 1'b0, 1'b0);
    do_instr(OP_STORE, 15, 15, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      do_instr(ops[$urandom_range(0, 8)],
               ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
               $urandom_range(0, 4), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0));
    end
    do_instr(OP_JAL, 0, 0, 1'b0, 1'b1);
    run = 1'b0;
    repeat (2) step();
    chk("final_idle", int'(state_dbg), 0);
    chk("final_no_req", int'(imem_req), 0);
    chk("final_instret", int'(instret), exp_cnt);
    chk("sb_empty", sb.size(), 0);
    chk("trace_empty", exp_st.size(), 0);
    mon_en = 0;

    // Illegal opcode
    rst = 1'b1; step(); rst = 1'b0; run = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin step(); n++; end
    chk("ill_fetch", int'(imem_req), 1);
    opcode = 7'b1111111;
    {reg_write, mem_read, mem_write, branch, jump} = 5'b00000;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("ill_decode", int'(state_dbg), 2);
    step();
    chk("ill_trap_state", int'(state_dbg), 6);
    chk("ill_flag", int'(illegal_trap), 1);
    chk("ill_no_buserr", int'(bus_err_trap), 0);
    bad = 0;
    repeat (20) begin
      step();
      if (state_dbg != 3'd6 || imem_req || dmem_req || retire || rf_we) bad++;
    end
    chk("ill_absorbing", bad, 0);
    chk("ill_instret", int'(instret), 0);

    // Fetch timeout
    rst = 1'b1; step(); rst = 1'b0;
    chk("trap_cleared", int'(illegal_trap), 0);
    n = 0;
    while (!imem_req && n < 10) begin step(); n++; end
    n = 0;
    while (state_dbg == 3'd1 && n < 40) begin step(); n++; end
    chk("buserr_fetch_cycles", n, MAX_WAIT);
    chk("buserr_state", int'(state_dbg), 6);
    chk("buserr_flag", int'(bus_err_trap), 1);
    chk("buserr_no_illegal", int'(illegal_trap), 0);

    // Reset during MEM of a store
    rst = 1'b1; step(); rst = 1'b0; run = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin step(); n++; end
    opcode = OP_STORE;
    {reg_write, mem_read, mem_write, branch, jump} = ctrl_of(OP_STORE);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    n = 0;
    while (!dmem_req && n < 10) begin step(); n++; end
    chk("st_mem_req", int'(dmem_req), 1);
    step();
    rt0 = retire_total;
    #2;
    rst = 1'b1;
    #1;
    chk("async_dmem_req", int'(dmem_req), 0);
    chk("async_state", int'(state_dbg), 0);
    chk("async_retire", int'(retire), 0);
    run = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    chk("rst_no_retire", retire_total - rt0, 0);
    chk("rst_instret_zero", int'(instret), 0);
    chk("rst_idle", int'(state_dbg), 0);
    chk("rst_dmem_idle", int'(dmem_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
